// File: rtl/barker_stream_checker.sv
// Self-checking AXI-Stream sink for the oversampled Barker-11 stream: majority-decodes
// each chip, compares frames with the golden sequence and reports one record per frame.
module barker_stream_checker #(
  parameter int                  SAMPLES_PER_CHIP = 4,
  parameter int                  SEQ_LEN          = 11,
  parameter logic [SEQ_LEN-1:0]  GOLDEN_SEQ       = 11'b11100010010,
  parameter int                  CNT_W            = 16,
  localparam int                 FRAME_BEATS      = SEQ_LEN * SAMPLES_PER_CHIP,
  localparam int                 ERR_W            = $clog2(SEQ_LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  input  logic             i_stall,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [ERR_W-1:0] o_res_errors,
  output logic             o_res_match,
  output logic             o_res_len_err,
  output logic [CNT_W-1:0] o_frames_ok,
  output logic [CNT_W-1:0] o_frames_bad
);

  // state   | meaning
  // COLLECT | accumulating samples/chips of the current frame
  // REPORT  | result record valid, input stalled until consumed
  // DRAIN   | after an early close: discard tlast beats up to the next frame
  typedef enum logic [1:0] {COLLECT, REPORT, DRAIN} state_t;

  localparam int BEAT_W = $clog2(FRAME_BEATS);
  localparam int SAMP_W = $clog2(SAMPLES_PER_CHIP);
  localparam int ONES_W = $clog2(SAMPLES_PER_CHIP + 1);
  localparam int CHIP_W = $clog2(SEQ_LEN);

  localparam logic [BEAT_W-1:0] TAIL_START = BEAT_W'(FRAME_BEATS - SAMPLES_PER_CHIP);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(FRAME_BEATS - 1);
  localparam logic [SAMP_W-1:0] LAST_SAMP  = SAMP_W'(SAMPLES_PER_CHIP - 1);
  localparam logic [ONES_W:0]   HALF_X2    = (ONES_W + 1)'(SAMPLES_PER_CHIP);

  function automatic logic [SEQ_LEN-1:0] reverse_bits(input logic [SEQ_LEN-1:0] v);
    logic [SEQ_LEN-1:0] r;
    for (int i = 0; i < SEQ_LEN; i++) r[i] = v[SEQ_LEN-1-i];
    return r;
  endfunction

  // Indexed by chip number, so chip 0 maps to the first-received golden bit.
  localparam logic [SEQ_LEN-1:0] GOLD_REV = reverse_bits(GOLDEN_SEQ);

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [SAMP_W-1:0]  samp_q, samp_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic [CHIP_W-1:0]  chip_q, chip_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               len_err_q, len_err_d;
  logic               early_q, early_d;
  logic [ERR_W-1:0]   res_errors_q, res_errors_d;
  logic               res_len_err_q, res_len_err_d;
  logic               res_match_q, res_match_d;
  logic [CNT_W-1:0]   ok_q, ok_d;
  logic [CNT_W-1:0]   bad_q, bad_d;

  logic               accept, process, in_tail, chip_end, chip_err, close_len_err;
  logic [ONES_W-1:0]  ones_n;
  logic [ONES_W:0]    ones_x2;
  logic [ERR_W-1:0]   err_n;

  assign s_axis_tready = !i_rst && !i_stall && (state_q != REPORT);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    samp_d        = samp_q;
    ones_d        = ones_q;
    chip_d        = chip_q;
    err_d         = err_q;
    len_err_d     = len_err_q;
    early_d       = early_q;
    res_errors_d  = res_errors_q;
    res_len_err_d = res_len_err_q;
    res_match_d   = res_match_q;
    ok_d          = ok_q;
    bad_d         = bad_q;

    accept   = s_axis_tvalid && s_axis_tready;
    process  = accept && ((state_q == COLLECT) || (state_q == DRAIN && !s_axis_tlast));
    in_tail  = beat_q >= TAIL_START;
    chip_end = samp_q == LAST_SAMP;
    ones_n   = ones_q + ONES_W'(s_axis_tdata);
    ones_x2  = {ones_n, 1'b0};
    // A tie is never a valid decision; otherwise compare the majority bit with golden.
    chip_err = (ones_x2 == HALF_X2) || ((ones_x2 > HALF_X2) != GOLD_REV[chip_q]);
    err_n    = err_q + ERR_W'(chip_end && chip_err);
    close_len_err = !in_tail || len_err_q || !s_axis_tlast;

    if (state_q == REPORT && i_res_ready) begin
      state_d = early_q ? DRAIN : COLLECT;
      if (res_match_q) begin
        if (ok_q != '1) ok_d = ok_q + CNT_W'(1);
      end else begin
        if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
      end
    end

    if (process) begin
      state_d = COLLECT;
      if (chip_end) begin
        samp_d = '0;
        ones_d = '0;
        chip_d = chip_q + CHIP_W'(1);
        err_d  = err_n;
      end else begin
        samp_d = samp_q + SAMP_W'(1);
        ones_d = ones_n;
      end

      if ((s_axis_tlast && !in_tail) || beat_q == LAST_BEAT) begin
        res_errors_d  = err_n;
        res_len_err_d = close_len_err;
        res_match_d   = (err_n == '0) && !close_len_err;
        early_d       = !in_tail;
        state_d       = REPORT;
        beat_d        = '0;
        samp_d        = '0;
        ones_d        = '0;
        chip_d        = '0;
        err_d         = '0;
        len_err_d     = 1'b0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
        if (in_tail && !s_axis_tlast) len_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= COLLECT;
      beat_q        <= '0;
      samp_q        <= '0;
      ones_q        <= '0;
      chip_q        <= '0;
      err_q         <= '0;
      len_err_q     <= 1'b0;
      early_q       <= 1'b0;
      res_errors_q  <= '0;
      res_len_err_q <= 1'b0;
      res_match_q   <= 1'b0;
      ok_q          <= '0;
      bad_q         <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      samp_q        <= samp_d;
      ones_q        <= ones_d;
      chip_q        <= chip_d;
      err_q         <= err_d;
      len_err_q     <= len_err_d;
      early_q       <= early_d;
      res_errors_q  <= res_errors_d;
      res_len_err_q <= res_len_err_d;
      res_match_q   <= res_match_d;
      ok_q          <= ok_d;
      bad_q         <= bad_d;
    end
  end

  assign o_res_valid   = state_q == REPORT;
  assign o_res_errors  = res_errors_q;
  assign o_res_len_err = res_len_err_q;
  assign o_res_match   = res_match_q;
  assign o_frames_ok   = ok_q;
  assign o_frames_bad  = bad_q;

endmodule
